jk_excitation_driver: RTL and testbench

- Inverse-direction companion to the JK flip-flop bank: accepts target WIDTH-bit state words over a valid/ready handshake.
- Derives per-bit J/K excitation from the JK excitation table against the bank's current Q, drives it for one clock, then reads the bank back to confirm the target was reached.
- Sits between a control/sequencer block and a bank of WIDTH JK flip-flops on the same clock; provides done/error status and a saturating error counter.

---
 rtl/jk_excitation_driver.sv | 125 ++++++++++++
 tb/tb_jk_excitation_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// rtl/jk_excitation_driver.sv - JK excitation driver with readback check; optional retry via JKD_RETRY_EN
module jk_excitation_driver #(
  parameter int WIDTH         = 4,
  parameter int PREFER_TOGGLE = 0,
  parameter int MAX_RETRY     = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       err_cnt
);

`ifdef JKD_RETRY_EN
  localparam int RETRY_LIMIT = MAX_RETRY;
`else
  localparam int RETRY_LIMIT = 0;
`endif
  // With retry disabled the limit is zero, so the retry counter is constant and folds away.
  localparam int              RW        = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0]   RETRY_MAX = RW'(RETRY_LIMIT);
  localparam logic            TOG       = (PREFER_TOGGLE != 0);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   tgt_q, tgt_d;
  logic [WIDTH-1:0]   j_q, j_d, k_q, k_d;
  logic               done_q, done_d, err_q, err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic [RW-1:0]      retry_q, retry_d;
  logic [2*WIDTH-1:0] jk_acc, jk_retry;

  // Excitation table: unchanged bits get JK=00; changing bits set/reset, or toggle when preferred.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] cur,
                                                input logic [WIDTH-1:0] nxt);
    logic [WIDTH-1:0] rise, fall;
    rise = ~cur & nxt;
    fall = cur & ~nxt;
    return {rise | (fall & {WIDTH{TOG}}), fall | (rise & {WIDTH{TOG}})};
  endfunction

  assign jk_acc   = excite(q_fb, tgt_data);
  assign jk_retry = excite(q_fb, tgt_q);

  assign tgt_ready = (state_q == IDLE);
  assign busy      = (state_q == DRIVE) || (state_q == CHECK);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

  // Next-state: accept in IDLE, drive one cycle, then judge the readback.
  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    j_d       = '0;
    k_d       = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    retry_d   = retry_q;
    unique case (state_q)
      IDLE: begin
        if (tgt_valid) begin
          tgt_d      = tgt_data;
          {j_d, k_d} = jk_acc;
          retry_d    = '0;
          state_d    = DRIVE;
        end
      end
      DRIVE: begin
        state_d = CHECK;
      end
      CHECK: begin
        if (q_fb == tgt_q) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (retry_q < RETRY_MAX) begin
          retry_d    = retry_q + RW'(1);
          {j_d, k_d} = jk_retry;
          state_d    = DRIVE;
        end else begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any word in flight and releases the bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tgt_q     <= '0;
      j_q       <= '0;
      k_q       <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      j_q       <= j_d;
      k_q       <= k_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      retry_q   <= retry_d;
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// tb/tb_jk_excitation_driver.sv - randomized reference-model bench for jk_excitation_driver (both toggle modes)
`timescale 1ns/1ps
module tb_jk_excitation_driver;
  localparam int W         = 4;
  localparam int MAX_RETRY = 2;
`ifdef JKD_RETRY_EN
  localparam int RETRIES = MAX_RETRY;
`else
  localparam int RETRIES = 0;
`endif

  typedef struct packed {
    logic [3:0] j;
    logic [3:0] k;
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cnt;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tgt_valid = 1'b0;
  logic [3:0] tgt_data = 4'h0;
  logic [3:0] stuck_mask = 4'h0;

  logic [3:0] j_w [2];
  logic [3:0] k_w [2];
  logic [3:0] q_fb_w [2];
  logic [3:0] bank_q [2];
  logic       ready_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       err_w [2];
  logic [7:0] cnt_w [2];

  int         n_tests = 0;
  int         n_fail = 0;
  logic [3:0] q_m [2];
  logic [7:0] cnt_m [2];
  int         len [2];
  int         pos [2];
  rec_t       sched [2][16];
  bit         accepted;

  always #5 clk = ~clk;

  function automatic logic [3:0] apply_jk(input logic [3:0] q, input logic [3:0] jj, input logic [3:0] kk);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      case ({jj[i], kk[i]})
        2'b10:   r[i] = 1'b1;
        2'b01:   r[i] = 1'b0;
        2'b11:   r[i] = ~q[i];
        default: r[i] = q[i];
      endcase
    end
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [3:0] bq;
    jk_excitation_driver #(.WIDTH(W), .PREFER_TOGGLE(g), .MAX_RETRY(MAX_RETRY)) u_dut (
      .clk(clk), .reset_n(reset_n), .tgt_valid(tgt_valid), .tgt_ready(ready_w[g]),
      .tgt_data(tgt_data), .q_fb(q_fb_w[g]), .j(j_w[g]), .k(k_w[g]), .busy(busy_w[g]),
      .done(done_w[g]), .err(err_w[g]), .err_cnt(cnt_w[g]));
    always @(posedge clk or negedge reset_n) begin
      if (!reset_n) bq <= 4'h0;
      else          bq <= apply_jk(bq, j_w[g], k_w[g]);
    end
    assign bank_q[g] = bq;
    assign q_fb_w[g] = bq & ~stuck_mask;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void excite(input logic [3:0] cur, input logic [3:0] nxt, input int pt,
                                 output logic [3:0] jj, output logic [3:0] kk);
    for (int i = 0; i < 4; i++) begin
      if (cur[i] == nxt[i]) begin jj[i] = 1'b0; kk[i] = 1'b0; end
      else if (nxt[i])      begin jj[i] = 1'b1; kk[i] = (pt != 0); end
      else                  begin kk[i] = 1'b1; jj[i] = (pt != 0); end
    end
  endfunction

  function automatic rec_t mk(input logic [3:0] jj, input logic [3:0] kk, input logic [3:0] q,
                              input logic b, input logic d, input logic e, input logic [7:0] c);
    rec_t r;
    r.j = jj; r.k = kk; r.q = q; r.busy = b; r.done = d; r.err = e; r.cnt = c;
    return r;
  endfunction

  function automatic rec_t idle_rec(input int m);
    return mk(4'h0, 4'h0, q_m[m], 1'b0, 1'b0, 1'b0, cnt_m[m]);
  endfunction

  // Expected per-cycle timeline for one accepted word: DRIVE/CHECK pairs, then the done cycle.
  task automatic build(input int m, input logic [3:0] tgt);
    logic [3:0] q, jj, kk;
    logic [7:0] cnt;
    int n;
    bit pass;
    q = q_m[m]; cnt = cnt_m[m]; n = 0; pass = 0;
    for (int a = 0; a <= RETRIES; a++) begin
      excite(q & ~stuck_mask, tgt, m, jj, kk);
      sched[m][n] = mk(jj, kk, q, 1'b1, 1'b0, 1'b0, cnt); n++;
      q = apply_jk(q, jj, kk);
      sched[m][n] = mk(4'h0, 4'h0, q, 1'b1, 1'b0, 1'b0, cnt); n++;
      if ((q & ~stuck_mask) == tgt) begin pass = 1; break; end
    end
    if (!pass) cnt = (cnt == 8'hFF) ? 8'hFF : cnt + 8'd1;
    sched[m][n] = mk(4'h0, 4'h0, q, 1'b0, 1'b1, !pass, cnt); n++;
    len[m] = n; pos[m] = 0; q_m[m] = q; cnt_m[m] = cnt;
  endtask

  task automatic step(input logic v, input logic [3:0] d);
    rec_t e [2];
    @(negedge clk);
    accepted = 0;
    for (int m = 0; m < 2; m++) begin
      e[m] = (pos[m] < len[m]) ? sched[m][pos[m]] : idle_rec(m);
      chk($sformatf("dut%0d.j", m),     j_w[m],     e[m].j);
      chk($sformatf("dut%0d.k", m),     k_w[m],     e[m].k);
      chk($sformatf("dut%0d.busy", m),  busy_w[m],  e[m].busy);
      chk($sformatf("dut%0d.ready", m), ready_w[m], !e[m].busy);
      chk($sformatf("dut%0d.done", m),  done_w[m],  e[m].done);
      chk($sformatf("dut%0d.err", m),   err_w[m],   e[m].err);
      chk($sformatf("dut%0d.cnt", m),   cnt_w[m],   e[m].cnt);
      chk($sformatf("dut%0d.bank_q", m), bank_q[m], e[m].q);
      if (pos[m] < len[m]) pos[m]++;
    end
    tgt_valid = v;
    tgt_data  = d;
    for (int m = 0; m < 2; m++) begin
      if (v && !e[m].busy) begin build(m, d); accepted = 1; end
    end
  endtask

  task automatic send(input logic [3:0] w);
    int tries = 0;
    do begin
      step(1'b1, w);
      tries++;
    end while (!accepted && tries < 16);
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while ((pos[0] < len[0] || pos[1] < len[1]) && n < 32) begin
      step(1'b0, 4'($urandom));
      n++;
    end
    step(1'b0, 4'h0);
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("rst%0d.j", m),    j_w[m],    32'd0);
      chk($sformatf("rst%0d.k", m),    k_w[m],    32'd0);
      chk($sformatf("rst%0d.done", m), done_w[m], 32'd0);
      chk($sformatf("rst%0d.err", m),  err_w[m],  32'd0);
      chk($sformatf("rst%0d.cnt", m),  cnt_w[m],  32'd0);
      q_m[m] = 4'h0; cnt_m[m] = 8'd0; len[m] = 0; pos[m] = 0;
    end
    tgt_valid = 1'b0;
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      q_m[m] = 4'h0; cnt_m[m] = 8'd0; len[m] = 0; pos[m] = 0;
    end
    repeat (3) @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("init%0d.j", m),    j_w[m],    32'd0);
      chk($sformatf("init%0d.k", m),    k_w[m],    32'd0);
      chk($sformatf("init%0d.done", m), done_w[m], 32'd0);
      chk($sformatf("init%0d.cnt", m),  cnt_w[m],  32'd0);
      chk($sformatf("init%0d.bank", m), bank_q[m], 32'd0);
    end
    #2 reset_n = 1'b1;
    repeat (2) step(1'b0, 4'h0);

    send(4'b1010);
    send(4'b0110);
    send(4'b0110);
    send(4'b1111);
    drain();

    repeat (200) step(1'($urandom_range(0, 1)), 4'($urandom));
    drain();

    pulse_reset();
    step(1'b0, 4'h0);
    step(1'b1, 4'b1000);
    step(1'b0, 4'h0);
    pulse_reset();
    step(1'b0, 4'h0);
    send(4'b0001);
    drain();

    pulse_reset();
    step(1'b0, 4'h0);
    stuck_mask = 4'b0001;
    send(4'b0001);
    drain();
    repeat (258) send(4'($urandom) | 4'd1);
    drain();
    stuck_mask = 4'b0000;
    step(1'b0, 4'h0);
    repeat (60) step(1'($urandom_range(0, 1)), 4'($urandom));
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
